// File: rtl/kurso_pkg.sv
// kurso shared constants.
// Counter limits for the binary and decade paths.
package kurso_pkg;

  localparam int BIN_MAX = 15;
  localparam int QUIN_MAX = 4;
  localparam int DEC_MAX = 9;
  localparam logic [3:0] DEC_TC = 4'd9;

endpackage

// File: rtl/kurso_mod_n_counter.sv
// Generic modulo-(MAX+1) up counter.
// Out-of-range values collapse to 0 on the next advance.
module mod_n_counter #(
  parameter int WIDTH = 4,
  parameter int MAX = 15
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);

  // count register: reset wins, then wrap at or above MAX
  always_ff @(posedge clk) begin
    if (RST) begin
      q <= '0;
    end else if (en) begin
      if (q >= MAX_Q) begin
        q <= '0;
      end else begin
        q <= q + 1'b1;
      end
    end
  end

  // terminal count, ungated
  always_comb begin
    tc = (q == MAX_Q);
  end

endmodule

// File: rtl/kurso.sv
// Binary (74161) plus biquinary decade (7490) counters.
// All stages share one count enable.
module kurso
  import kurso_pkg::*;
(
  input  logic       clk,
  input  logic       RST,
  input  logic       EN,
  output logic [3:0] chet,
  output logic       one_two,
  output logic       one_ten_0,
  output logic       zero_five_1,
  output logic       zero_five_2,
  output logic       zero_five_3,
  output logic [3:0] one_zero_0
);

  logic [2:0] q5;
  logic       q5_en;
  logic       dec_tc;
  logic       bin_tc_unused;
  logic       two_tc_unused;
  logic       q5_tc_unused;

  // QA feeds CKB: quinary steps as one_two falls
  assign q5_en = EN & one_two;

  mod_n_counter #(.WIDTH(4), .MAX(BIN_MAX)) u_bin (
    .clk (clk),
    .RST (RST),
    .en  (EN),
    .q   (chet),
    .tc  (bin_tc_unused)
  );

  mod_n_counter #(.WIDTH(1), .MAX(1)) u_two (
    .clk (clk),
    .RST (RST),
    .en  (EN),
    .q   (one_two),
    .tc  (two_tc_unused)
  );

  mod_n_counter #(.WIDTH(3), .MAX(QUIN_MAX)) u_five (
    .clk (clk),
    .RST (RST),
    .en  (q5_en),
    .q   (q5),
    .tc  (q5_tc_unused)
  );

  mod_n_counter #(.WIDTH(4), .MAX(DEC_MAX)) u_dec (
    .clk (clk),
    .RST (RST),
    .en  (EN),
    .q   (one_zero_0),
    .tc  (dec_tc)
  );

  // split quinary bits and gate the ripple-carry style flag
  always_comb begin
    zero_five_1 = q5[0];
    zero_five_2 = q5[1];
    zero_five_3 = q5[2];
    one_ten_0 = EN & dec_tc;
  end

endmodule

// File: tb/tb_kurso.sv
// Directed and randomized checks for kurso.
// Expected values are hand-computed or from a small model.
module tb_kurso;

  logic       clk;
  logic       RST;
  logic       EN;
  logic [3:0] chet;
  logic       one_two;
  logic       one_ten_0;
  logic       zero_five_1;
  logic       zero_five_2;
  logic       zero_five_3;
  logic [3:0] one_zero_0;

  int tests;
  int fails;

  kurso dut (
    .clk         (clk),
    .RST         (RST),
    .EN          (EN),
    .chet        (chet),
    .one_two     (one_two),
    .one_ten_0   (one_ten_0),
    .zero_five_1 (zero_five_1),
    .zero_five_2 (zero_five_2),
    .zero_five_3 (zero_five_3),
    .one_zero_0  (one_zero_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input logic r, input logic e);
    RST = r;
    EN = e;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [3:0] e_chet,
                         input logic e_two,
                         input logic [2:0] e_five,
                         input logic [3:0] e_dec,
                         input logic e_tc);
    logic [2:0] five;
    five = {zero_five_3, zero_five_2, zero_five_1};
    chk({tag, ".chet"}, 8'(chet), 8'(e_chet));
    chk({tag, ".one_two"}, 8'(one_two), 8'(e_two));
    chk({tag, ".zero_five"}, 8'(five), 8'(e_five));
    chk({tag, ".one_zero_0"}, 8'(one_zero_0), 8'(e_dec));
    chk({tag, ".one_ten_0"}, 8'(one_ten_0), 8'(e_tc));
  endtask

  initial begin
    logic [3:0] m_chet;
    logic [3:0] m_dec;
    logic       r;
    logic       e;
    tests = 0;
    fails = 0;
    RST = 1'b1;
    EN = 1'b1;

    tick(1, 1);
    tick(1, 1);
    chk_all("reset", 4'd0, 1'b0, 3'd0, 4'd0, 1'b0);

    repeat (9) tick(0, 1);
    chk_all("count9", 4'd9, 1'b1, 3'b100, 4'd9, 1'b1);

    tick(0, 1);
    chk_all("count10", 4'd10, 1'b0, 3'd0, 4'd0, 1'b0);

    tick(1, 1);
    repeat (16) tick(0, 1);
    chk_all("count16", 4'd0, 1'b0, 3'b011, 4'd6, 1'b0);

    tick(1, 1);
    repeat (9) tick(0, 1);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0);
      chk_all("hold", 4'd9, 1'b1, 3'b100, 4'd9, 1'b0);
    end
    tick(0, 1);
    chk_all("resume", 4'd10, 1'b0, 3'd0, 4'd0, 1'b0);

    tick(1, 1);
    repeat (7) tick(0, 1);
    chk_all("at7", 4'd7, 1'b1, 3'b011, 4'd7, 1'b0);
    tick(1, 1);
    chk_all("midrst", 4'd0, 1'b0, 3'd0, 4'd0, 1'b0);
    tick(0, 1);
    chk_all("afterrst", 4'd1, 1'b1, 3'd0, 4'd1, 1'b0);

    m_chet = 4'd1;
    m_dec = 4'd1;
    for (int i = 0; i < 500; i++) begin
      r = ($urandom_range(0, 24) == 0);
      e = 1'($urandom_range(0, 1));
      tick(r, e);
      if (r) begin
        m_chet = 4'd0;
        m_dec = 4'd0;
      end else if (e) begin
        m_chet = m_chet + 4'd1;
        m_dec = (m_dec == 4'd9) ? 4'd0 : m_dec + 4'd1;
      end
      chk_all("rand", m_chet, m_dec[0], m_dec[3:1], m_dec,
              e & (m_dec == 4'd9));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
